// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package regfile_pkg;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREQ = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_req_t;

   typedef logic [2**AW-1:0] pend_mask_t;

   function automatic pend_mask_t addr_onehot(input logic [AW-1:0] a);
      return pend_mask_t'(1'b1) << a;
   endfunction

endpackage

// File: rtl/rr_age_arb2.sv
// Two-way writeback grant: single holder wins; two holders resolve by age
// when they target the same register, otherwise by round-robin priority.
module rr_age_arb2 import regfile_pkg::*; (
   input  logic [NREQ-1:0] held,
   input  logic            same_addr,
   input  logic            pri,
   input  logic            old,
   output logic [NREQ-1:0] gnt
);

   logic sel_s;

   assign sel_s = same_addr ? old : pri;

   // One-hot grant selection from the holding state.
   always_comb begin
      gnt = 2'b00;
      case (held)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = sel_s ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU (port 0) and load (port 1)
// writeback paths. Optional REGFILE_ZERO_REG_EN drops all writes to register 0.
module regfile_wb_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ0_VALID,
   input  logic [AW-1:0]    REQ0_ADDR,
   input  logic [DW-1:0]    REQ0_DATA,
   output logic             REQ0_READY,
   input  logic             REQ1_VALID,
   input  logic [AW-1:0]    REQ1_ADDR,
   input  logic [DW-1:0]    REQ1_DATA,
   output logic             REQ1_READY,
   output logic [AW-1:0]    A3,
   output logic [DW-1:0]    WD3,
   output logic             WE3,
   output logic [2**AW-1:0] PEND_MASK
);
   import regfile_pkg::*;

   logic [NREQ-1:0] held_r;
   logic [NREQ-1:0] gnt_s;
   logic [NREQ-1:0] ready_s;
   logic [NREQ-1:0] valid_s;
   logic [NREQ-1:0] store_s;
   logic [NREQ-1:0] stay_s;
   wb_req_t         hold_r [NREQ];
   wb_req_t         req_s  [NREQ];
   logic            pri_r;
   logic            old_r;
   logic            same_addr_s;
   pend_mask_t      pend_s;

   assign valid_s     = {REQ1_VALID, REQ0_VALID};
   assign req_s[0]    = {REQ0_ADDR, REQ0_DATA};
   assign req_s[1]    = {REQ1_ADDR, REQ1_DATA};
   assign same_addr_s = (hold_r[0].addr == hold_r[1].addr);

   rr_age_arb2 u_arb (
      .held      (held_r),
      .same_addr (same_addr_s),
      .pri       (pri_r),
      .old       (old_r),
      .gnt       (gnt_s)
   );

   // Handshake: a granted slot may refill on its write edge.
   always_comb begin
      ready_s = ~held_r | gnt_s;
      stay_s  = held_r & ~gnt_s;
      for (int n = 0; n < NREQ; n++) begin
`ifdef REGFILE_ZERO_REG_EN
         store_s[n] = valid_s[n] & ready_s[n] & (req_s[n].addr != {AW{1'b0}});
`else
         store_s[n] = valid_s[n] & ready_s[n];
`endif
      end
   end

   assign REQ0_READY = ready_s[0];
   assign REQ1_READY = ready_s[1];

   // Holding registers and their valid bits.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         held_r    <= 2'b00;
         hold_r[0] <= '0;
         hold_r[1] <= '0;
      end else begin
         held_r <= store_s | stay_s;
         for (int n = 0; n < NREQ; n++) begin
            if (store_s[n]) begin
               hold_r[n] <= req_s[n];
            end
         end
      end
   end

   // Round-robin pointer and age marker; OLD names the port whose entry is older.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pri_r <= 1'b0;
         old_r <= 1'b0;
      end else begin
         if (gnt_s[0]) begin
            pri_r <= 1'b1;
         end else if (gnt_s[1]) begin
            pri_r <= 1'b0;
         end
         if (&store_s) begin
            old_r <= 1'b0;
         end else if (stay_s[0] && store_s[1]) begin
            old_r <= 1'b0;
         end else if (stay_s[1] && store_s[0]) begin
            old_r <= 1'b1;
         end
      end
   end

   // Write port mux and in-flight register mask.
   always_comb begin
      WE3    = |gnt_s;
      A3     = {AW{1'b0}};
      WD3    = {DW{1'b0}};
      pend_s = '0;
      case (gnt_s)
         2'b01: begin
            A3  = hold_r[0].addr;
            WD3 = hold_r[0].data;
         end
         2'b10: begin
            A3  = hold_r[1].addr;
            WD3 = hold_r[1].data;
         end
         default: begin
            A3  = {AW{1'b0}};
            WD3 = {DW{1'b0}};
         end
      endcase
      for (int n = 0; n < NREQ; n++) begin
         pend_s = pend_s | (held_r[n] ? addr_onehot(hold_r[n].addr) : pend_mask_t'(1'b0));
      end
   end

   assign PEND_MASK = pend_s;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (A3/WD3/WE3) between two writeback requesters: port 0 for ALU results and port 1 for memory loads. Each port has a valid/ready handshake and a one-entry holding register. The arbiter grants one write per cycle, round-robin, and preserves arrival order when both requesters target the same register. It also exports a pending-write mask so decode can stall reads of registers that are in flight.

Parameters:
AW, 5, register address width; matches the A3 width.
DW, 32, data width; matches the WD3 width.

Ports:
CLK  input  1  system clock, rising-edge.
RST_N  input  1  asynchronous active-low reset.
REQ0_VALID  input  1  port 0 write request valid.
REQ0_ADDR  input  AW  port 0 destination register.
REQ0_DATA  input  DW  port 0 write data.
REQ0_READY  output  1  port 0 holding register can accept.
REQ1_VALID  input  1  port 1 write request valid.
REQ1_ADDR  input  AW  port 1 destination register.
REQ1_DATA  input  DW  port 1 write data.
REQ1_READY  output  1  port 1 holding register can accept.
A3  output  AW  register file write address.
WD3  output  DW  register file write data.
WE3  output  1  register file write enable.
PEND_MASK  output  2**AW  bit a set iff a held entry targets register a.

Behaviour:
- Clock and reset:
  - Single clock CLK; reset RST_N is asynchronous and active-low.
  - Reset clears both holding valids (HELD0/HELD1 = 0), PRI = 0 (port 0 favoured), OLD = 0.
  - During and after reset: WE3 = 0, A3 = 0, WD3 = 0, PEND_MASK = 0, REQn_READY = 1.
  - Reset mid-operation discards held entries; no write is issued for them.
- Handshake:
  - Accept on a rising edge when REQn_VALID & REQn_READY; ADDR and DATA are captured into holding register n.
  - REQn_READY = ~HELDn | GNTn (combinational). A port refills in the same cycle it is granted, so one port sustains 1 write/cycle.
  - VALID may drop without READY; nothing is captured in that case.
- Grant (combinational from holding state):
  - Only one held -> grant it.
  - Both held, addresses differ -> grant the port indicated by PRI.
  - Both held, same address -> grant the port indicated by OLD (the older entry).
  - None held -> no grant; WE3 = 0, A3 = 0, WD3 = 0.
- Write port:
  - WE3 = any grant; A3/WD3 come from the granted entry.
  - The register file writes at the next rising edge, so accept-to-write latency is 1 cycle (accepted at edge k, written at edge k+1).
  - The granted HELD bit clears at that edge unless it is refilled.
- PRI update: after any grant to port p, PRI <= ~p. Otherwise PRI is unchanged.
- OLD update, evaluated at each edge on the next-state:
  - Both newly loaded on the same edge -> OLD <= 0.
  - One entry stays held (not granted) while the other loads -> OLD <= staying port.
  - Both stay held -> OLD unchanged.
- PEND_MASK: OR of one-hot(ADDRn) over held entries, combinational. A granted entry stays in the mask until its write edge.
- Consequence: 2 writes to the same register drain strictly in arrival order, and no write is ever lost or reordered within a port.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined: requests with ADDR == 0 are accepted (READY follows the normal rule) but never stored. The HELD bit is not set, PEND_MASK bit 0 is never set, and no WE3 is issued, so register 0 always reads zero.
- Undefined: address 0 is handled like any other register.

Decomposition:
- Package regfile_pkg holds:
  - localparams AW=5, DW=32, NREQ=2;
  - typedef wb_req_t struct {addr[AW-1:0], data[DW-1:0]};
  - typedef pend_mask_t logic[2**AW-1:0].
- One sub-module, rr_age_arb2: inputs held[1:0], same_addr, PRI, OLD; output a one-hot gnt[1:0]. It is purely combinational.
- Holding registers, PRI/OLD state and the mask logic live in the top.

Test Plan:
- Reset -> WE3=0, A3=0, PEND_MASK=0, both READY=1. Assert RST_N low while both are held -> no WE3 afterwards.
- Port 0 alone sends addr 3 data 0xDEADBEEF -> next cycle WE3=1, A3=3, WD3=0xDEADBEEF, PEND_MASK=0x8. Back-to-back addresses 1,2,4 -> 1 write per cycle, READY stays 1.
- Both ports stream continuously, port 0 to addr 5, port 1 to addr 6 -> grants alternate 0,1,0,1 from reset, and each READY toggles accordingly.
- Port 1 sends addr 7 data 0x11; one cycle later port 0 sends addr 7 data 0x22 while port 1 is still held -> writes 0x11 then 0x22, and reg7 ends at 0x22.
- Both ports load addr 2 on the same edge (0xAA on port 0, 0xBB on port 1) -> port 0 is written first, final value 0xBB. PEND_MASK=0x4 until the second write.
- Port 0 writes addr 0 data 0x5 -> with REGFILE_ZERO_REG_EN: READY=1, WE3 never asserts, PEND_MASK stays 0. Without the macro: WE3=1, A3=0, WD3=0x5.
